// File: rtl/alu_unit.sv
// Integer ALU for the MIPS-subset datapath. It decodes R-type funct codes.
// The result and the Zero flag are registered, which gives one cycle of latency.
module alu_unit #(
   parameter int DATA_W  = 32,
   parameter int SHAMT_W = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DATA_W-1:0]   Src1,
   input  logic [DATA_W-1:0]   Src2,
   input  logic [5:0]          funct,
   input  logic [SHAMT_W-1:0]  shamt,
   output logic [DATA_W-1:0]   aluResult,
   output logic                Zero
);

   localparam logic [5:0] FUNCT_ADDU = 6'b001001;
   localparam logic [5:0] FUNCT_SUBU = 6'b001010;
   localparam logic [5:0] FUNCT_AND  = 6'b010001;
   localparam logic [5:0] FUNCT_OR   = 6'b010010;
   localparam logic [5:0] FUNCT_SLL  = 6'b100001;
   localparam logic [5:0] FUNCT_SRL  = 6'b100010;

   logic [DATA_W-1:0] next_result;
   logic              next_zero;

   // Undefined funct codes produce zero. Carry and borrow are dropped by truncation.
   always_comb begin
      next_result = '0;
      case (funct)
         FUNCT_ADDU: next_result = Src1 + Src2;
         FUNCT_SUBU: next_result = Src1 - Src2;
         FUNCT_AND:  next_result = Src1 & Src2;
         FUNCT_OR:   next_result = Src1 | Src2;
         FUNCT_SLL:  next_result = Src2 << shamt;
         FUNCT_SRL:  next_result = Src2 >> shamt;
         default:    next_result = '0;
      endcase
   end

   assign next_zero = (next_result == '0);

   // Zero comes from the same next value, so both registers always move together.
   always_ff @(posedge clk) begin
      if (rst) begin
         aluResult <= '0;
         Zero      <= 1'b1;
      end else begin
         aluResult <= next_result;
         Zero      <= next_zero;
      end
   end

endmodule

// File: tb/tb_alu_unit.sv
// Directed bench for alu_unit. A plain-arithmetic model predicts every cycle,
// and hand-computed literals pin both the model and the DUT.
module tb_alu_unit;

   logic        clk;
   logic        rst;
   logic [31:0] Src1;
   logic [31:0] Src2;
   logic [5:0]  funct;
   logic [4:0]  shamt;
   logic [31:0] aluResult;
   logic        Zero;

   int checks_total  = 0;
   int checks_passed = 0;

   logic [32:0] exp_q[$];

   alu_unit #(.DATA_W(32), .SHAMT_W(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .Src1      (Src1),
      .Src2      (Src2),
      .funct     (funct),
      .shamt     (shamt),
      .aluResult (aluResult),
      .Zero      (Zero)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, actual timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   // Model: results are computed on 64-bit integers and reduced modulo 2^32.
   // Returns {zero, result}.
   function automatic logic [32:0] model(input logic r, input logic [31:0] a,
                                         input logic [31:0] b, input logic [5:0] f,
                                         input logic [4:0] s);
      longint unsigned m;
      longint unsigned ua;
      longint unsigned ub;
      longint unsigned pw;
      longint unsigned res;
      m   = 64'h1_0000_0000;
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      pw  = 64'd1 << s;
      res = 0;
      if (r) res = 0;
      else begin
         case (f)
            6'b001001: res = (ua + ub) % m;
            6'b001010: res = (ua + m - ub) % m;
            6'b010001: res = {32'd0, a & b};
            6'b010010: res = {32'd0, a | b};
            6'b100001: res = (ub * pw) % m;
            6'b100010: res = ub / pw;
            default:   res = 0;
         endcase
      end
      return {(res == 0), res[31:0]};
   endfunction

   // Model prediction at each active edge, using the inputs sampled there
   always @(posedge clk) begin
      exp_q.push_back(model(rst, Src1, Src2, funct, shamt));
   end

   // Compare process: checks every cycle, away from the active edge
   always @(negedge clk) begin
      logic [32:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks_total++;
         if (aluResult === e[31:0] && Zero === e[32]) checks_passed++;
         else $display("FAIL model_cmp: actual result=%h zero=%b, required result=%h zero=%b",
                       aluResult, Zero, e[31:0], e[32]);
      end
   end

   // Driver task: apply one op. Check the literal against the model, then against the DUT after the edge.
   task automatic apply(input string name, input logic r, input logic [31:0] a,
                        input logic [31:0] b, input logic [5:0] f, input logic [4:0] s,
                        input logic [31:0] exp_res, input logic exp_z);
      logic [32:0] m;
      @(negedge clk);
      rst = r; Src1 = a; Src2 = b; funct = f; shamt = s;
      m = model(r, a, b, f, s);
      checks_total++;
      if (m === {exp_z, exp_res}) checks_passed++;
      else $display("FAIL model_pin %s: actual result=%h zero=%b, required result=%h zero=%b",
                    name, m[31:0], m[32], exp_res, exp_z);
      @(posedge clk);
      #1;
      checks_total++;
      if (aluResult === exp_res && Zero === exp_z) checks_passed++;
      else $display("FAIL %s: actual result=%h zero=%b, required result=%h zero=%b",
                    name, aluResult, Zero, exp_res, exp_z);
   endtask

   initial begin
      rst = 1'b1; Src1 = '0; Src2 = '0; funct = '0; shamt = '0;
      apply("reset",       1'b1, 32'h000000F0, 32'd15, 6'b001001, 5'd0, 32'h00000000, 1'b1);
      apply("addu",        1'b0, 32'h000000F0, 32'd15, 6'b001001, 5'd0, 32'h000000FF, 1'b0);
      apply("subu",        1'b0, 32'h000000F0, 32'd15, 6'b001010, 5'd0, 32'h000000E1, 1'b0);
      apply("or",          1'b0, 32'h000000F0, 32'd15, 6'b010010, 5'd0, 32'h000000FF, 1'b0);
      apply("and_zero",    1'b0, 32'h000000F0, 32'd15, 6'b010001, 5'd0, 32'h00000000, 1'b1);
      apply("and",         1'b0, 32'hF0F0FFFF, 32'h0FF0F00F, 6'b010001, 5'd7, 32'h00F0F00F, 1'b0);
      apply("srl",         1'b0, 32'h00000000, 32'd15, 6'b100010, 5'd4, 32'h00000000, 1'b1);
      apply("sll",         1'b0, 32'h00000000, 32'd15, 6'b100001, 5'd4, 32'h000000F0, 1'b0);
      apply("subu_eq",     1'b0, 32'd15, 32'd15, 6'b001010, 5'd0, 32'h00000000, 1'b1);
      apply("subu_wrap",   1'b0, 32'd0, 32'd1, 6'b001010, 5'd0, 32'hFFFFFFFF, 1'b0);
      apply("addu_wrap",   1'b0, 32'hFFFFFFFF, 32'd1, 6'b001001, 5'd0, 32'h00000000, 1'b1);
      apply("sll_31",      1'b0, 32'h0, 32'd1, 6'b100001, 5'd31, 32'h80000000, 1'b0);
      apply("srl_31",      1'b0, 32'h0, 32'h80000000, 6'b100010, 5'd31, 32'h00000001, 1'b0);
      apply("sll_shamt0",  1'b0, 32'h0, 32'h12345678, 6'b100001, 5'd0, 32'h12345678, 1'b0);
      apply("srl_shamt0",  1'b0, 32'h0, 32'h87654321, 6'b100010, 5'd0, 32'h87654321, 1'b0);
      apply("sll_drop",    1'b0, 32'h0, 32'hF000000F, 6'b100001, 5'd8, 32'h00000F00, 1'b0);
      apply("addu_shamt",  1'b0, 32'h00000100, 32'h00000023, 6'b001001, 5'd9, 32'h00000123, 1'b0);
      apply("undef",       1'b0, 32'h000000F0, 32'd15, 6'b111111, 5'd3, 32'h00000000, 1'b1);
      apply("undef_0",     1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'b000000, 5'd1, 32'h00000000, 1'b1);
      apply("pre_rst",     1'b0, 32'hDEADBEEF, 32'h00000001, 6'b010010, 5'd0, 32'hDEADBEEF, 1'b0);
      apply("rst_mid",     1'b1, 32'h000000F0, 32'd15, 6'b001001, 5'd0, 32'h00000000, 1'b1);
      apply("after_rst",   1'b0, 32'h000000F0, 32'd15, 6'b001001, 5'd0, 32'h000000FF, 1'b0);
      apply("or_all",      1'b0, 32'hAAAA5555, 32'h5555AAAA, 6'b010010, 5'd0, 32'hFFFFFFFF, 1'b0);
      @(negedge clk);
      funct = 6'b111111;
      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
